// File: rtl/fifo_rd_stream_pkg.sv
// Shared sizing helpers and parameter limits for the async-FIFO read-side stream adapter.
package fifo_rd_stream_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int DEPTH_DEF = 3;
    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 8;

    // Occupancy counter must hold the value DEPTH itself, hence depth+1.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int idx_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic bit depth_legal(input int depth);
        return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying prefetched FIFO words to the read-domain consumer.
interface fifo_rd_stream_if #(
    parameter int DSIZE = 8
);
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the async FIFO: issues fetches, absorbs the one-cycle memory
// read latency in a small prefetch buffer and presents the words as a valid/ready stream.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int  DSIZE = DSIZE_DEF,
    parameter int  DEPTH = DEPTH_DEF,
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             flush,
    input  logic             rempty,
    output logic             rinc,
    input  logic [DSIZE-1:0] rdata,
    fifo_rd_stream_if.master m,
    output logic [CNT_W-1:0] buf_cnt
);

    localparam int IDX_W = idx_w(DEPTH);

    generate
        if (!depth_legal(DEPTH)) begin : g_bad_depth
            $error("fifo_rd_stream: DEPTH must be within 2..8");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inflight_q, inflight_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [DSIZE-1:0] buf_q [DEPTH];

    logic [CNT_W:0]   occ;
    logic             room;
    logic             capture;
    logic             pop;

    // DEPTH need not be a power of two, so wrap explicitly at DEPTH-1.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Buffered plus in-flight words bound the fetch, so a capture always has a free slot.
    assign occ     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inflight_q};
    assign room    = (occ < (CNT_W + 1)'(DEPTH));
    assign rinc    = rrst_n & ~flush & ~rempty & room;

    assign m.m_valid = rrst_n & ~flush & (cnt_q != '0);
    assign m.m_data  = buf_q[rd_idx_q];
    assign buf_cnt   = cnt_q;

    assign pop     = m.m_valid & m.m_ready;
    assign capture = rrst_n & ~flush & inflight_q;

    always_comb begin
        cnt_d      = cnt_q;
        inflight_d = inflight_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        if (flush) begin
            cnt_d      = '0;
            inflight_d = 1'b0;
            wr_idx_d   = '0;
            rd_idx_d   = '0;
        end else begin
            inflight_d = rinc;
            if (capture) begin
                wr_idx_d = idx_inc(wr_idx_q);
            end
            if (pop) begin
                rd_idx_d = idx_inc(rd_idx_q);
            end
            cnt_d = cnt_q + CNT_W'(capture) - CNT_W'(pop);
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
        end
    end

    // Storage needs no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge rclk) begin
        if (capture) begin
            buf_q[wr_idx_q] <= rdata;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: DEPTH=3 and DEPTH=2 instances fed from a modelled FIFO and
// checked every cycle against a queue-based model, plus hand-computed scenario checks.
module tb_fifo_rd_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic flush;
    logic m_ready;

    // Modelled upstream FIFO: shared write side, one read pointer per instance.
    logic [7:0] mem [1024];
    int         wptr;
    int         rptr [2];
    logic [7:0] rdata_r [2];

    wire  [1:0] rempty_w;
    wire  [1:0] rinc_w;
    wire  [1:0] vld_w;
    wire  [7:0] dat_w [2];
    wire  [1:0] cnt_w [2];

    assign rempty_w[0] = (rptr[0] == wptr);
    assign rempty_w[1] = (rptr[1] == wptr);

    fifo_rd_stream_if #(.DSIZE(8)) s3 ();
    fifo_rd_stream_if #(.DSIZE(8)) s2 ();

    assign s3.m_ready = m_ready;
    assign s2.m_ready = m_ready;
    assign vld_w      = {s2.m_valid, s3.m_valid};
    assign dat_w[0]   = s3.m_data;
    assign dat_w[1]   = s2.m_data;

    fifo_rd_stream #(.DSIZE(8), .DEPTH(3)) u_d3 (
        .rclk    (clk),
        .rrst_n  (rst_n),
        .flush   (flush),
        .rempty  (rempty_w[0]),
        .rinc    (rinc_w[0]),
        .rdata   (rdata_r[0]),
        .m       (s3),
        .buf_cnt (cnt_w[0])
    );

    fifo_rd_stream #(.DSIZE(8), .DEPTH(2)) u_d2 (
        .rclk    (clk),
        .rrst_n  (rst_n),
        .flush   (flush),
        .rempty  (rempty_w[1]),
        .rinc    (rinc_w[1]),
        .rdata   (rdata_r[1]),
        .m       (s2),
        .buf_cnt (cnt_w[1])
    );

    // Behavioural model: buffered words as a queue plus one pending fetched word.
    logic [7:0] mq [2][$];
    bit         infl [2];
    logic [7:0] infl_w [2];

    int         n_checks;
    int         n_pass;
    int         cyc;
    bit         started;
    int         rinc_cnt3;
    logic [7:0] got3 [$];
    int         pop_cyc3 [$];
    logic [7:0] got2 [$];

    function automatic int dep(input int d);
        return (d == 0) ? 3 : 2;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push(input logic [7:0] w);
        if (wptr < 1024) begin
            mem[wptr] = w;
            wptr++;
        end
    endtask

    task automatic tick();
        bit er [2];
        bit ev [2];
        bit fa [2];
        int ecnt;
        #1;
        for (int d = 0; d < 2; d++) begin
            ecnt  = mq[d].size();
            ev[d] = rst_n && !flush && (ecnt != 0);
            er[d] = rst_n && !flush && !rempty_w[d] && ((ecnt + int'(infl[d])) < dep(d));
            fa[d] = rinc_w[d];
            chk($sformatf("rinc_d%0d", dep(d)), rinc_w[d], er[d]);
            chk($sformatf("m_valid_d%0d", dep(d)), vld_w[d], ev[d]);
            if (started) begin
                chk($sformatf("buf_cnt_d%0d", dep(d)), cnt_w[d], ecnt);
                chk($sformatf("cnt_bound_d%0d", dep(d)), (int'(cnt_w[d]) <= dep(d)), 1);
            end
            if (ev[d]) begin
                chk($sformatf("m_data_d%0d", dep(d)), dat_w[d], mq[d][0]);
            end
            if (vld_w[d] && m_ready) begin
                $display("xfer depth=%0d cyc=%0d data=%02h", dep(d), cyc, dat_w[d]);
                if (d == 0) begin
                    got3.push_back(dat_w[0]);
                    pop_cyc3.push_back(cyc);
                end else begin
                    got2.push_back(dat_w[1]);
                end
            end
        end
        if (rinc_w[0]) rinc_cnt3++;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n || flush) begin
                mq[d].delete();
                infl[d] = 1'b0;
            end else begin
                if (ev[d] && m_ready) void'(mq[d].pop_front());
                if (infl[d]) mq[d].push_back(infl_w[d]);
                infl[d] = er[d];
                if (er[d]) infl_w[d] = mem[rptr[d]];
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (fa[d]) begin
                rdata_r[d] = mem[rptr[d]];
                rptr[d]++;
            end else begin
                rdata_r[d] = 8'($urandom);
            end
        end
        started = 1'b1;
        cyc++;
    endtask

    initial begin
        int n0;
        int rel;
        n_checks  = 0;
        n_pass    = 0;
        cyc       = 0;
        started   = 1'b0;
        rinc_cnt3 = 0;
        wptr      = 0;
        rptr[0]   = 0;
        rptr[1]   = 0;
        rdata_r[0] = 8'h00;
        rdata_r[1] = 8'h00;
        infl[0]   = 1'b0;
        infl[1]   = 1'b0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        m_ready   = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));

        // Reset held with a non-empty FIFO: no fetch may be issued.
        repeat (3) begin
            #1 chk("reset_rinc", rinc_w[0], 1'b0);
            tick();
        end

        rst_n   = 1'b1;
        m_ready = 1'b1;
        rel     = cyc;
        #1 chk("release_rinc", rinc_w[0], 1'b1);
        tick();
        tick();
        #1;
        chk("first_valid", vld_w[0], 1'b1);
        chk("first_cnt", cnt_w[0], 2'd1);
        chk("first_data", dat_w[0], 8'h10);

        repeat (40) tick();
        chk("stream_len3", got3.size(), 16);
        chk("stream_len2", got2.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < got3.size()) begin
                chk("stream_data3", got3[i], 8'h10 + 8'(i));
                chk("stream_cyc3", pop_cyc3[i], rel + 2 + i);
            end
            if (i < got2.size()) chk("stream_data2", got2[i], 8'h10 + 8'(i));
        end

        // Back-pressure: buffers fill to their depth and the head holds.
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        repeat (6) tick();
        #1;
        chk("bp_cnt3", cnt_w[0], 2'd3);
        chk("bp_rinc3", rinc_w[0], 1'b0);
        chk("bp_valid3", vld_w[0], 1'b1);
        chk("bp_data3", dat_w[0], 8'h20);
        chk("bp_cnt2", cnt_w[1], 2'd2);
        n0 = got3.size();
        m_ready = 1'b1;
        repeat (40) tick();
        chk("bp_len3", got3.size() - n0, 16);
        for (int i = 0; i < 16; i++) begin
            if (n0 + i < got3.size()) chk("bp_order3", got3[n0 + i], 8'h20 + 8'(i));
        end

        // Single word into an empty FIFO.
        rinc_cnt3 = 0;
        n0 = got3.size();
        push(8'hA5);
        repeat (6) tick();
        #1;
        chk("single_rinc_pulses", rinc_cnt3, 1);
        chk("single_xfers", got3.size() - n0, 1);
        if (n0 < got3.size()) chk("single_data", got3[n0], 8'hA5);
        chk("single_idle_valid", vld_w[0], 1'b0);
        chk("single_idle_rinc", rinc_w[0], 1'b0);

        // Flush with two buffered words and one in flight.
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
        repeat (3) tick();
        #1 chk("preflush_cnt3", cnt_w[0], 2'd2);
        flush = 1'b1;
        #1 chk("flush_valid3", vld_w[0], 1'b0);
        tick();
        flush   = 1'b0;
        m_ready = 1'b1;
        #1;
        chk("postflush_cnt3", cnt_w[0], 2'd0);
        chk("postflush_valid3", vld_w[0], 1'b0);
        n0 = got3.size();
        repeat (12) tick();
        chk("postflush_len3", got3.size() - n0, 5);
        if (n0 < got3.size()) chk("postflush_next3", got3[n0], 8'h33);

        // Random traffic with occasional flush and reset pulses.
        repeat (400) begin
            rst_n   = ($urandom_range(0, 149) != 0);
            flush   = ($urandom_range(0, 39) == 0);
            m_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 1) push(8'($urandom));
            tick();
        end
        rst_n   = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b1;
        repeat (30) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
